// File: rtl/lcd_pkg.sv
// lcd_pkg
//  Shared definitions for the character-LCD bus driver:
//   - HD44780 command bytes used by the init sequence and by upstream sequencers
//   - width of the millisecond wait counters
//   - state encoding of the bus-driver FSM
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_FUNC    = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_ENTRY   = 8'h06;  // increment, no shift
    localparam logic [7:0] CMD_LINE2   = 8'hC0;  // DDRAM address of line 2

    // Number of writes in the power-on init sequence.
    localparam int INIT_LEN = 6;

    // Width of the power-wait / settle counters.
    localparam int TMR_W = 5;

    typedef enum logic [2:0] {
        PWR_WAIT,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        SETTLE,
        ACK
    } lcd_state_t;

endpackage

// File: rtl/lcd_ms_timer.sv
// lcd_ms_timer
//  Load/count/expire down-counter in units of CLK1K cycles.
//  A wait of N cycles is loaded with N; "expired" is high during the last
//  cycle of the wait (count <= 1), so the owner leaves its wait state on the
//  edge that ends the N-th cycle. The counter stops at zero and never wraps.
//  Ports:
//   CLK1K     in  clock
//   RSTN      in  asynchronous active-low reset (counter takes RST_VAL)
//   load      in  load load_val this edge (has priority over count)
//   load_val  in  wait length in cycles
//   count     in  decrement this edge
//   expired   out high during the final cycle of the current wait
module lcd_ms_timer #(
    parameter int            W       = 5,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         CLK1K,
    input  logic         RSTN,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         count,
    output logic         expired
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt;

    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    assign expired = (cnt <= ONE);

endmodule

// File: rtl/lcd_bus_ctrl.sv
// lcd_bus_ctrl
//  HD44780-style character-LCD bus driver on a 1 kHz clock. After reset it
//  waits for panel power-up, pushes the init ROM through the write engine,
//  then serves single-byte writes requested with START_IN, acknowledging
//  each user write with a one-cycle DONE_OUT after the LCD settle time.
//
//  Handshake: START_IN is a one-cycle request qualified by nothing else;
//  DATA_IN/RS_IN are sampled on the same edge. Every request lands in a
//  one-entry pending buffer; a request arriving while the buffer is full is
//  dropped (the first one wins), except on the edge where IDLE hands the
//  buffered entry to the write engine, when the new request refills it.
//  DONE_OUT pulses once per executed user write; BUSY_OUT is low only in
//  IDLE with an empty buffer.
//
//  Ports:
//   CLK1K, RSTN        clock, asynchronous active-low reset
//   DATA_IN, RS_IN     byte and register select of the request
//   START_IN           request pulse
//   DONE_OUT           user write finished (including settle)
//   BUSY_OUT           init running, write in progress or request pending
//   LCD_DATA, LCD_RS   LCD bus; hold their last value while idle
//   LCD_ENABLE         EN strobe
//   LCD_RW             tied low (write only)
//   LCD_ON, LCD_BLON   panel power and backlight, on from the first edge
module lcd_bus_ctrl
    import lcd_pkg::*;
#(
    parameter int INIT_WAIT_MS = 20,
    parameter int CLR_WAIT_MS  = 2,
    parameter int CHAR_WAIT_MS = 1,
    parameter int EN_HIGH_CYC  = 1
) (
    input  logic       CLK1K,
    input  logic       RSTN,
    input  logic [7:0] DATA_IN,
    input  logic       RS_IN,
    input  logic       START_IN,
    output logic       DONE_OUT,
    output logic       BUSY_OUT,
    output logic [7:0] LCD_DATA,
    output logic       LCD_ENABLE,
    output logic       LCD_RW,
    output logic       LCD_RS,
    output logic       LCD_ON,
    output logic       LCD_BLON
);

    localparam logic [TMR_W-1:0] INIT_WAIT_V = TMR_W'(INIT_WAIT_MS);
    localparam logic [TMR_W-1:0] CLR_WAIT_V  = TMR_W'(CLR_WAIT_MS);
    localparam logic [TMR_W-1:0] CHAR_WAIT_V = TMR_W'(CHAR_WAIT_MS);
    localparam logic [TMR_W-1:0] EN_HIGH_V   = TMR_W'(EN_HIGH_CYC);
    localparam logic [2:0]       INIT_LAST   = 3'(INIT_LEN);

    lcd_state_t state_q, state_d;

    // Write currently on the bus; drives LCD_DATA/LCD_RS directly.
    logic [7:0] cur_data_q;
    logic       cur_rs_q;

    // One-entry request buffer.
    logic       pend_valid_q;
    logic [7:0] pend_data_q;
    logic       pend_rs_q;

    // Init sequencing: index of the next ROM entry to issue.
    logic       in_init_q;
    logic [2:0] init_idx_q;
    logic [7:0] rom_data;

    logic       lcd_on_q;

    // Timer control and FSM side effects.
    logic                 tmr_load;
    logic [TMR_W-1:0]     tmr_val;
    logic                 tmr_count;
    logic                 tmr_expired;
    logic                 issue_init;
    logic                 issue_pend;
    logic                 init_finish;
    logic                 slow_cmd;

    lcd_ms_timer #(
        .W       (TMR_W),
        .RST_VAL (INIT_WAIT_V)
    ) u_timer (
        .CLK1K    (CLK1K),
        .RSTN     (RSTN),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .expired  (tmr_expired)
    );

    // Power-on init ROM.
    always_comb begin
        rom_data = CMD_FUNC;
        case (init_idx_q)
            3'd0:    rom_data = CMD_FUNC;
            3'd1:    rom_data = CMD_FUNC;
            3'd2:    rom_data = CMD_FUNC;
            3'd3:    rom_data = CMD_DISP_ON;
            3'd4:    rom_data = CMD_CLEAR;
            3'd5:    rom_data = CMD_ENTRY;
            default: rom_data = CMD_FUNC;
        endcase
    end

    // Clear and home need the long settle; everything else the short one.
    assign slow_cmd = !cur_rs_q && ((cur_data_q == CMD_CLEAR) || (cur_data_q == CMD_HOME));

    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= PWR_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmr_load    = 1'b0;
        tmr_val     = EN_HIGH_V;
        tmr_count   = 1'b0;
        issue_init  = 1'b0;
        issue_pend  = 1'b0;
        init_finish = 1'b0;
        case (state_q)
            PWR_WAIT: begin
                tmr_count = 1'b1;
                if (tmr_expired) begin
                    issue_init = 1'b1;
                    state_d    = SETUP;
                end
            end
            IDLE: begin
                if (pend_valid_q) begin
                    issue_pend = 1'b1;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                tmr_load = 1'b1;
                tmr_val  = EN_HIGH_V;
                state_d  = PULSE;
            end
            PULSE: begin
                tmr_count = 1'b1;
                if (tmr_expired) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                tmr_load = 1'b1;
                tmr_val  = slow_cmd ? CLR_WAIT_V : CHAR_WAIT_V;
                state_d  = SETTLE;
            end
            SETTLE: begin
                tmr_count = 1'b1;
                if (tmr_expired) begin
                    if (!in_init_q) begin
                        state_d = ACK;
                    end else if (init_idx_q == INIT_LAST) begin
                        // Init writes are never acknowledged upstream.
                        init_finish = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        issue_init = 1'b1;
                        state_d    = SETUP;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = PWR_WAIT;
            end
        endcase
    end

    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            cur_data_q   <= 8'h00;
            cur_rs_q     <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= 8'h00;
            pend_rs_q    <= 1'b0;
            in_init_q    <= 1'b1;
            init_idx_q   <= 3'd0;
            lcd_on_q     <= 1'b0;
        end else begin
            lcd_on_q <= 1'b1;

            if (issue_init) begin
                cur_data_q <= rom_data;
                cur_rs_q   <= 1'b0;
                init_idx_q <= init_idx_q + 3'd1;
            end else if (issue_pend) begin
                cur_data_q <= pend_data_q;
                cur_rs_q   <= pend_rs_q;
            end

            if (init_finish) begin
                in_init_q <= 1'b0;
            end

            // The buffer accepts a request when empty or when its entry is
            // being handed to the write engine on this same edge.
            if (START_IN && (!pend_valid_q || issue_pend)) begin
                pend_valid_q <= 1'b1;
                pend_data_q  <= DATA_IN;
                pend_rs_q    <= RS_IN;
            end else if (issue_pend) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

    assign LCD_ENABLE = (state_q == PULSE);
    assign DONE_OUT   = (state_q == ACK);
    assign BUSY_OUT   = !((state_q == IDLE) && !pend_valid_q);
    assign LCD_DATA   = cur_data_q;
    assign LCD_RS     = cur_rs_q;
    assign LCD_RW     = 1'b0;
    assign LCD_ON     = lcd_on_q;
    assign LCD_BLON   = lcd_on_q;

endmodule
